// File: rtl/wb_switch.sv
// Wishbone switch from the Zet CPU master port to up to eight slaves.
// The address decode picks one slave per bus cycle and a watchdog bounds every cycle.
module wb_switch #(
    parameter int                 NSLV     = 4,
    parameter logic [8*NSLV-1:0]  MEM_BASE = '0,
    parameter logic [8*NSLV-1:0]  MEM_MASK = '0,
    parameter logic [15*NSLV-1:0] IO_BASE  = '0,
    parameter logic [15*NSLV-1:0] IO_MASK  = '0,
    parameter int                 DEF_SLV  = 0,
    parameter int                 TOUT     = 255,
    parameter int                 TW       = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,

    input  logic [15:0]          m_dat_i,
    input  logic [19:1]          m_adr_i,
    input  logic                 m_we_i,
    input  logic                 m_tga_i,
    input  logic                 m_stb_i,
    input  logic                 m_cyc_i,
    input  logic [1:0]           m_sel_i,
    output logic [15:0]          m_dat_o,
    output logic                 m_ack_o,
    output logic                 err_o,

    output logic [15:0]          s_dat_o,
    output logic [19:1]          s_adr_o,
    output logic                 s_we_o,
    output logic [1:0]           s_sel_o,
    output logic                 s_tga_o,
    output logic [NSLV-1:0]      s_stb_o,
    output logic [NSLV-1:0]      s_cyc_o,
    input  logic [16*NSLV-1:0]   s_dat_i,
    input  logic [NSLV-1:0]      s_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK
    } state_t;

    state_t          state;
    logic [NSLV-1:0] sel;
    logic [NSLV-1:0] stb;
    logic [TW-1:0]   cnt;

    logic [NSLV-1:0] mem_hit;
    logic [NSLV-1:0] io_hit;
    logic [NSLV-1:0] hit;
    logic [NSLV-1:0] pick;
    logic            io_miss;
    logic            ack_hit;
    logic            timeout;
    logic [15:0]     rdata;

    assign s_dat_o = m_dat_i;
    assign s_adr_o = m_adr_i;
    assign s_we_o  = m_we_i;
    assign s_sel_o = m_sel_i;
    assign s_tga_o = m_tga_i;
    assign s_stb_o = stb;
    assign s_cyc_o = stb;

    // A window with an all-zero mask is disabled rather than matching everything.
    always_comb begin
        mem_hit = '0;
        io_hit  = '0;
        for (int i = 0; i < NSLV; i++) begin
            mem_hit[i] = (MEM_MASK[8*i +: 8] != 8'h00) &&
                         (((m_adr_i[19:12] ^ MEM_BASE[8*i +: 8]) & MEM_MASK[8*i +: 8]) == 8'h00);
            io_hit[i]  = (IO_MASK[15*i +: 15] != 15'h0000) &&
                         (((m_adr_i[15:1] ^ IO_BASE[15*i +: 15]) & IO_MASK[15*i +: 15]) == 15'h0000);
        end
    end

    assign hit     = m_tga_i ? io_hit : mem_hit;
    assign io_miss = m_tga_i && (io_hit == '0);

    // Scanning downwards leaves the lowest-index hit as the winner.
    always_comb begin
        pick = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (hit[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
        if ((hit == '0) && !m_tga_i) begin
            pick[DEF_SLV] = 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel[i]) begin
                rdata = rdata | s_dat_i[16*i +: 16];
            end
        end
    end

    assign ack_hit = |(s_ack_i & sel);
    assign timeout = (cnt == TW'(TOUT - 1));

    // Abort beats a slave ack, which in turn beats the watchdog.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state   <= IDLE;
            sel     <= '0;
            stb     <= '0;
            cnt     <= '0;
            m_ack_o <= 1'b0;
            m_dat_o <= '0;
            err_o   <= 1'b0;
        end else begin
            m_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_stb_i && m_cyc_i) begin
                        if (io_miss) begin
                            m_dat_o <= 16'h0000;
                            m_ack_o <= 1'b1;
                            state   <= ACK;
                        end else begin
                            sel   <= pick;
                            stb   <= pick;
                            cnt   <= '0;
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (!m_cyc_i) begin
                        stb   <= '0;
                        state <= IDLE;
                    end else if (ack_hit) begin
                        m_dat_o <= rdata;
                        m_ack_o <= 1'b1;
                        stb     <= '0;
                        state   <= ACK;
                    end else if (timeout) begin
                        m_dat_o <= 16'hFFFF;
                        m_ack_o <= 1'b1;
                        err_o   <= 1'b1;
                        stb     <= '0;
                        state   <= ACK;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_switch.sv
// Directed bench for wb_switch: four slaves, overlapping memory windows,
// one I/O window on slave 3 and a short watchdog.
module tb_wb_switch;

    localparam int NSLV = 4;
    localparam int TOUT = 4;

    logic                 clk;
    logic                 rst_n;
    logic [15:0]          m_dat_i;
    logic [19:1]          m_adr_i;
    logic                 m_we_i;
    logic                 m_tga_i;
    logic                 m_stb_i;
    logic                 m_cyc_i;
    logic [1:0]           m_sel_i;
    logic [15:0]          m_dat_o;
    logic                 m_ack_o;
    logic                 err_o;
    logic [15:0]          s_dat_o;
    logic [19:1]          s_adr_o;
    logic                 s_we_o;
    logic [1:0]           s_sel_o;
    logic                 s_tga_o;
    logic [NSLV-1:0]      s_stb_o;
    logic [NSLV-1:0]      s_cyc_o;
    logic [16*NSLV-1:0]   s_dat_i;
    logic [NSLV-1:0]      s_ack_i;

    int checks;
    int errors;

    wb_switch #(
        .NSLV     (NSLV),
        .MEM_BASE ({8'hA4, 8'hA0, 8'hB8, 8'h00}),
        .MEM_MASK ({8'hFC, 8'hF0, 8'hFF, 8'h00}),
        .IO_BASE  ({15'h01ED, 15'h0000, 15'h0000, 15'h0000}),
        .IO_MASK  ({15'h7FFF, 15'h0000, 15'h0000, 15'h0000}),
        .DEF_SLV  (0),
        .TOUT     (TOUT),
        .TW       (8)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .m_dat_i    (m_dat_i),
        .m_adr_i    (m_adr_i),
        .m_we_i     (m_we_i),
        .m_tga_i    (m_tga_i),
        .m_stb_i    (m_stb_i),
        .m_cyc_i    (m_cyc_i),
        .m_sel_i    (m_sel_i),
        .m_dat_o    (m_dat_o),
        .m_ack_o    (m_ack_o),
        .err_o      (err_o),
        .s_dat_o    (s_dat_o),
        .s_adr_o    (s_adr_o),
        .s_we_o     (s_we_o),
        .s_sel_o    (s_sel_o),
        .s_tga_o    (s_tga_o),
        .s_stb_o    (s_stb_o),
        .s_cyc_o    (s_cyc_o),
        .s_dat_i    (s_dat_i),
        .s_ack_i    (s_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each tick lands 1 time unit after a rising edge, i.e. at the start of the next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_master();
        m_stb_i = 1'b0;
        m_cyc_i = 1'b0;
        m_we_i  = 1'b0;
        m_tga_i = 1'b0;
        s_ack_i = '0;
    endtask

    task automatic start(input logic tga, input logic we, input logic [19:1] adr);
        m_tga_i = tga;
        m_we_i  = we;
        m_adr_i = adr;
        m_stb_i = 1'b1;
        m_cyc_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        release_master();
        tick();
        tick();
        checks++; if (m_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0", m_ack_o); end
        checks++; if (m_dat_o !== 16'h0000) begin errors++; $display("[TB] FAIL reset_dat: got %h expected 0000", m_dat_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err_o); end
        checks++; if ((s_stb_o !== 4'b0000) || (s_cyc_o !== 4'b0000)) begin errors++; $display("[TB] FAIL reset_stb: got stb %b cyc %b expected 0000", s_stb_o, s_cyc_o); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mem_read();
        s_dat_i = {16'h3333, 16'h2222, 16'h1234, 16'hBEEF};
        start(1'b0, 1'b0, 19'h5C008);
        tick();
        checks++; if ((s_stb_o !== 4'b0010) || (s_cyc_o !== 4'b0010)) begin errors++; $display("[TB] FAIL mem_read_stb: got stb %b cyc %b expected 0010", s_stb_o, s_cyc_o); end
        tick();
        checks++; if (m_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL mem_read_early_ack: got %b expected 0", m_ack_o); end
        s_ack_i = 4'b0010;
        tick();
        checks++; if ((m_ack_o !== 1'b1) || (m_dat_o !== 16'h1234)) begin errors++; $display("[TB] FAIL mem_read_ack: got ack %b dat %h expected 1 1234", m_ack_o, m_dat_o); end
        checks++; if (s_stb_o !== 4'b0000) begin errors++; $display("[TB] FAIL mem_read_stb_drop: got %b expected 0000", s_stb_o); end
        release_master();
        tick();
        checks++; if ((m_ack_o !== 1'b0) || (m_dat_o !== 16'h1234)) begin errors++; $display("[TB] FAIL mem_read_hold: got ack %b dat %h expected 0 1234", m_ack_o, m_dat_o); end
    endtask

    task automatic test_mem_default();
        start(1'b0, 1'b0, 19'h091A0);
        tick();
        checks++; if (s_stb_o !== 4'b0001) begin errors++; $display("[TB] FAIL mem_default_stb: got %b expected 0001", s_stb_o); end
        s_ack_i = 4'b0001;
        tick();
        checks++; if ((m_ack_o !== 1'b1) || (m_dat_o !== 16'hBEEF)) begin errors++; $display("[TB] FAIL mem_default_ack: got ack %b dat %h expected 1 beef", m_ack_o, m_dat_o); end
        release_master();
        tick();
    endtask

    task automatic test_overlap_unselected();
        start(1'b0, 1'b0, 19'h52800);
        tick();
        checks++; if (s_stb_o !== 4'b0100) begin errors++; $display("[TB] FAIL overlap_stb: got %b expected 0100", s_stb_o); end
        s_ack_i = 4'b1000;
        tick();
        checks++; if ((m_ack_o !== 1'b0) || (s_stb_o !== 4'b0100)) begin errors++; $display("[TB] FAIL unselected_ack: got ack %b stb %b expected 0 0100", m_ack_o, s_stb_o); end
        s_ack_i = 4'b0100;
        tick();
        checks++; if ((m_ack_o !== 1'b1) || (m_dat_o !== 16'h2222)) begin errors++; $display("[TB] FAIL overlap_ack: got ack %b dat %h expected 1 2222", m_ack_o, m_dat_o); end
        release_master();
        tick();
    endtask

    task automatic test_io_miss();
        start(1'b1, 1'b0, 19'h00030);
        tick();
        checks++; if ((m_ack_o !== 1'b1) || (m_dat_o !== 16'h0000)) begin errors++; $display("[TB] FAIL io_miss_ack: got ack %b dat %h expected 1 0000", m_ack_o, m_dat_o); end
        checks++; if (s_stb_o !== 4'b0000) begin errors++; $display("[TB] FAIL io_miss_stb: got %b expected 0000", s_stb_o); end
        release_master();
        tick();
        checks++; if (m_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL io_miss_single_ack: got %b expected 0", m_ack_o); end
    endtask

    task automatic test_io_write();
        m_dat_i = 16'hA55A;
        m_sel_i = 2'b11;
        start(1'b1, 1'b1, {4'h0, 15'h01ED});
        #1;
        checks++; if ((s_we_o !== 1'b1) || (s_dat_o !== 16'hA55A) || (s_tga_o !== 1'b1)) begin errors++; $display("[TB] FAIL io_write_bcast: got we %b dat %h tga %b expected 1 a55a 1", s_we_o, s_dat_o, s_tga_o); end
        checks++; if ((s_adr_o !== {4'h0, 15'h01ED}) || (s_sel_o !== 2'b11)) begin errors++; $display("[TB] FAIL io_write_adr: got adr %h sel %b expected 01ed 11", s_adr_o, s_sel_o); end
        tick();
        checks++; if (s_stb_o !== 4'b1000) begin errors++; $display("[TB] FAIL io_write_stb: got %b expected 1000", s_stb_o); end
        s_ack_i = 4'b1000;
        tick();
        checks++; if ((m_ack_o !== 1'b1) || (m_dat_o !== 16'h3333)) begin errors++; $display("[TB] FAIL io_write_ack: got ack %b dat %h expected 1 3333", m_ack_o, m_dat_o); end
        release_master();
        tick();
    endtask

    task automatic test_back_to_back();
        start(1'b1, 1'b0, 19'h00030);
        tick();
        checks++; if (m_ack_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_ack: got %b expected 1", m_ack_o); end
        tick();
        checks++; if (m_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap: got %b expected 0", m_ack_o); end
        tick();
        checks++; if (m_ack_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_ack: got %b expected 1", m_ack_o); end
        release_master();
        tick();
    endtask

    task automatic test_ack_on_timeout();
        s_dat_i[31:16] = 16'h5A5A;
        start(1'b0, 1'b0, 19'h5C008);
        tick();
        tick();
        tick();
        tick();
        checks++; if ((m_ack_o !== 1'b0) || (s_stb_o !== 4'b0010)) begin errors++; $display("[TB] FAIL late_ack_wait: got ack %b stb %b expected 0 0010", m_ack_o, s_stb_o); end
        s_ack_i = 4'b0010;
        tick();
        checks++; if ((m_ack_o !== 1'b1) || (m_dat_o !== 16'h5A5A) || (err_o !== 1'b0)) begin errors++; $display("[TB] FAIL late_ack_wins: got ack %b dat %h err %b expected 1 5a5a 0", m_ack_o, m_dat_o, err_o); end
        release_master();
        tick();
    endtask

    task automatic test_timeout();
        start(1'b0, 1'b0, 19'h5C008);
        for (int i = 0; i < TOUT; i++) begin
            tick();
        end
        checks++; if ((m_ack_o !== 1'b0) || (s_stb_o !== 4'b0010)) begin errors++; $display("[TB] FAIL timeout_early: got ack %b stb %b expected 0 0010", m_ack_o, s_stb_o); end
        tick();
        checks++; if ((m_ack_o !== 1'b1) || (m_dat_o !== 16'hFFFF) || (err_o !== 1'b1)) begin errors++; $display("[TB] FAIL timeout_ack: got ack %b dat %h err %b expected 1 ffff 1", m_ack_o, m_dat_o, err_o); end
        checks++; if (s_stb_o !== 4'b0000) begin errors++; $display("[TB] FAIL timeout_stb: got %b expected 0000", s_stb_o); end
        release_master();
        tick();
        start(1'b0, 1'b0, 19'h091A0);
        tick();
        s_ack_i = 4'b0001;
        tick();
        checks++; if ((m_ack_o !== 1'b1) || (m_dat_o !== 16'hBEEF) || (err_o !== 1'b1)) begin errors++; $display("[TB] FAIL err_sticky: got ack %b dat %h err %b expected 1 beef 1", m_ack_o, m_dat_o, err_o); end
        release_master();
        tick();
    endtask

    task automatic test_abort();
        start(1'b0, 1'b0, 19'h5C008);
        tick();
        checks++; if (s_stb_o !== 4'b0010) begin errors++; $display("[TB] FAIL abort_stb_on: got %b expected 0010", s_stb_o); end
        tick();
        m_stb_i = 1'b0;
        m_cyc_i = 1'b0;
        s_ack_i = 4'b0010;
        tick();
        checks++; if ((s_stb_o !== 4'b0000) || (m_ack_o !== 1'b0)) begin errors++; $display("[TB] FAIL abort_drop: got stb %b ack %b expected 0000 0", s_stb_o, m_ack_o); end
        s_ack_i = '0;
        tick();
        checks++; if ((m_ack_o !== 1'b0) || (m_dat_o !== 16'hBEEF)) begin errors++; $display("[TB] FAIL abort_no_ack: got ack %b dat %h expected 0 beef", m_ack_o, m_dat_o); end
    endtask

    task automatic test_reset_mid();
        start(1'b0, 1'b0, 19'h5C008);
        tick();
        checks++; if ((s_stb_o !== 4'b0010) || (err_o !== 1'b1)) begin errors++; $display("[TB] FAIL reset_mid_pre: got stb %b err %b expected 0010 1", s_stb_o, err_o); end
        tick();
        rst_n = 1'b0;
        release_master();
        tick();
        checks++; if ((s_stb_o !== 4'b0000) || (s_cyc_o !== 4'b0000) || (m_ack_o !== 1'b0)) begin errors++; $display("[TB] FAIL reset_mid_bus: got stb %b cyc %b ack %b expected 0000 0000 0", s_stb_o, s_cyc_o, m_ack_o); end
        checks++; if ((m_dat_o !== 16'h0000) || (err_o !== 1'b0)) begin errors++; $display("[TB] FAIL reset_mid_regs: got dat %h err %b expected 0000 0", m_dat_o, err_o); end
        rst_n = 1'b1;
        tick();
        start(1'b1, 1'b0, 19'h00030);
        tick();
        checks++; if (m_ack_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_mid_idle: got ack %b expected 1", m_ack_o); end
        release_master();
        tick();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        m_dat_i = '0;
        m_adr_i = '0;
        m_sel_i = 2'b11;
        s_dat_i = '0;
        release_master();
        #1;
        test_reset();
        test_mem_read();
        test_mem_default();
        test_overlap_unselected();
        test_io_miss();
        test_io_write();
        test_back_to_back();
        test_ack_on_timeout();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got %0d checks expected completion", checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
